// File: rtl/hit_detector_pkg.sv
// Shared types and default constants for the player hit detector.
// State encoding and counter widths are fixed here so game control can decode them.
package hit_detector_pkg;

    typedef enum logic [1:0] {
        ST_ARMED = 2'b00,
        ST_GRACE = 2'b01,
        ST_DEAD  = 2'b11
    } state_t;

    localparam int DEF_COORD_W      = 10;
    localparam int DEF_PLAYER_SZ    = 16;
    localparam int DEF_ENEMY_SZ     = 16;
    localparam int DEF_GRACE_FRAMES = 60;
    localparam int DEF_MAX_HITS     = 3;
    localparam int HIT_CNT_W        = 2;
    localparam int TIMER_W          = 8;

endpackage

// File: rtl/aabb_overlap.sv
// Combinational axis-aligned box overlap test; box A at (a_x,a_y), box B at (b_x,b_y).
// Edge sums use one extra bit so boxes near the right/bottom border never wrap.
module aabb_overlap
    import hit_detector_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int A_SZ    = DEF_PLAYER_SZ,
    parameter int B_SZ    = DEF_ENEMY_SZ
) (
    input  logic [COORD_W-1:0] i_a_x,
    input  logic [COORD_W-1:0] i_a_y,
    input  logic [COORD_W-1:0] i_b_x,
    input  logic [COORD_W-1:0] i_b_y,
    input  logic               i_valid,
    output logic               o_overlap
);

    logic [COORD_W:0] w_a_x_end;
    logic [COORD_W:0] w_a_y_end;
    logic [COORD_W:0] w_b_x_end;
    logic [COORD_W:0] w_b_y_end;

    assign w_a_x_end = {1'b0, i_a_x} + (COORD_W+1)'(A_SZ);
    assign w_a_y_end = {1'b0, i_a_y} + (COORD_W+1)'(A_SZ);
    assign w_b_x_end = {1'b0, i_b_x} + (COORD_W+1)'(B_SZ);
    assign w_b_y_end = {1'b0, i_b_y} + (COORD_W+1)'(B_SZ);

    // Strict compares: boxes that only share an edge are not overlapping.
    assign o_overlap = i_valid
                     & ({1'b0, i_a_x} < w_b_x_end)
                     & ({1'b0, i_b_x} < w_a_x_end)
                     & ({1'b0, i_a_y} < w_b_y_end)
                     & ({1'b0, i_b_y} < w_a_y_end);

endmodule

// File: rtl/hit_detector.sv
// Player/enemy collision to single-cycle hit pulse, with frame-based grace window and death.
// Build option HIT_REARM_EN: leaving grace also waits for the overlap to clear.
module hit_detector
    import hit_detector_pkg::*;
#(
    parameter int COORD_W      = DEF_COORD_W,
    parameter int PLAYER_SZ    = DEF_PLAYER_SZ,
    parameter int ENEMY_SZ     = DEF_ENEMY_SZ,
    parameter int GRACE_FRAMES = DEF_GRACE_FRAMES,
    parameter int MAX_HITS     = DEF_MAX_HITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_frame_tick,
    input  logic                 i_enable,
    input  logic [COORD_W-1:0]   i_player_x,
    input  logic [COORD_W-1:0]   i_player_y,
    input  logic [COORD_W-1:0]   i_enemy_x,
    input  logic [COORD_W-1:0]   i_enemy_y,
    input  logic                 i_enemy_valid,
    output logic                 o_was_hit,
    output logic                 o_invuln,
    output logic [HIT_CNT_W-1:0] o_hit_count,
    output logic                 o_dead
);

    logic                 w_ovl;
    logic                 r_coll_q;
    state_t               r_state;
    state_t               w_state_nxt;
    logic [TIMER_W-1:0]   r_timer;
    logic [TIMER_W-1:0]   w_timer_nxt;
    logic [HIT_CNT_W-1:0] r_hit_count;
    logic [HIT_CNT_W-1:0] w_hit_count_nxt;
    logic                 r_was_hit;
    logic                 w_was_hit_nxt;

    aabb_overlap #(
        .COORD_W (COORD_W),
        .A_SZ    (PLAYER_SZ),
        .B_SZ    (ENEMY_SZ)
    ) u_overlap (
        .i_a_x     (i_player_x),
        .i_a_y     (i_player_y),
        .i_b_x     (i_enemy_x),
        .i_b_y     (i_enemy_y),
        .i_valid   (i_enemy_valid),
        .o_overlap (w_ovl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coll_q    <= 1'b0;
            r_state     <= ST_ARMED;
            r_timer     <= '0;
            r_hit_count <= '0;
            r_was_hit   <= 1'b0;
        end else begin
            r_coll_q    <= w_ovl & i_enable;
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_hit_count <= w_hit_count_nxt;
            r_was_hit   <= w_was_hit_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = r_timer;
        w_hit_count_nxt = r_hit_count;
        w_was_hit_nxt   = 1'b0;
        case (r_state)
            ST_ARMED: begin
                // A frame tick coinciding with the hit is not charged to the new timer.
                if (r_coll_q) begin
                    w_was_hit_nxt   = 1'b1;
                    w_hit_count_nxt = r_hit_count + HIT_CNT_W'(1);
                    if (w_hit_count_nxt == HIT_CNT_W'(MAX_HITS)) begin
                        w_state_nxt = ST_DEAD;
                    end else begin
                        w_state_nxt = ST_GRACE;
                        w_timer_nxt = TIMER_W'(GRACE_FRAMES);
                    end
                end
            end
            ST_GRACE: begin
`ifdef HIT_REARM_EN
                if (r_timer == '0) begin
                    if (!r_coll_q) w_state_nxt = ST_ARMED;
                end else if (i_frame_tick) begin
                    w_timer_nxt = r_timer - TIMER_W'(1);
                    if (r_timer == TIMER_W'(1) && !r_coll_q) w_state_nxt = ST_ARMED;
                end
`else
                if (i_frame_tick) begin
                    w_timer_nxt = r_timer - TIMER_W'(1);
                    if (r_timer == TIMER_W'(1)) w_state_nxt = ST_ARMED;
                end
`endif
            end
            ST_DEAD: begin
                w_state_nxt = ST_DEAD;
            end
            default: begin
                w_state_nxt = ST_ARMED;
            end
        endcase
    end

    assign o_was_hit   = r_was_hit;
    assign o_invuln    = (r_state == ST_GRACE);
    assign o_dead      = (r_state == ST_DEAD);
    assign o_hit_count = r_hit_count;

endmodule
